// File: rtl/tick_period_meter_if.sv
// Tick-stream measurement bus for tick_period_meter.
//   tick_in  : tick stream (one high cycle per tick), driven by the source
//   k_out    : last measured interval (number of low cycles between ticks)
//   k_valid  : one-cycle strobe, k_out updated
//   overflow : one-cycle strobe, interval exceeded the counter range
//   locked   : stable-period indicator
// Modports: master = tick source / result consumer, slave = the meter.
interface tick_period_meter_if #(
  parameter int BIT_SZ = 16
);
  logic              tick_in;
  logic [BIT_SZ-1:0] k_out;
  logic              k_valid;
  logic              overflow;
  logic              locked;

  modport master (output tick_in, input k_out, k_valid, overflow, locked);
  modport slave  (input tick_in, output k_out, k_valid, overflow, locked);
endinterface

// File: rtl/tick_period_meter.sv
// tick_period_meter: recovers the divider setting k from a tick stream whose
// ticks repeat every k+1 cycles. The first tick arms the block; every later
// tick reports the number of low cycles since the previous tick.
//
// Ports:
//   clk_in : single clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : tick_period_meter_if.slave (tick_in in; k_out, k_valid,
//            overflow, locked out)
// Parameters:
//   BIT_SZ   : width of the measured interval
//   LOCK_CNT : consecutive identical measurements needed for locked (2..255)
// Build option:
//   TICK_PERIOD_LOCK_EN : when defined, the lock detector is built; when
//                         undefined, locked is tied to 0.
module tick_period_meter #(
  parameter int BIT_SZ   = 16,
  parameter int LOCK_CNT = 4
) (
  input  logic               clk_in,
  input  logic               rst_n,
  tick_period_meter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [BIT_SZ-1:0] GAP_MAX = {BIT_SZ{1'b1}};
  localparam logic [BIT_SZ-1:0] GAP_ONE = {{(BIT_SZ-1){1'b0}}, 1'b1};

  if (LOCK_CNT < 2 || LOCK_CNT > 255) begin : g_lock_cnt_range
    $error("tick_period_meter: LOCK_CNT must be in 2..255");
  end

  state_t            state_q, state_d;
  logic [BIT_SZ-1:0] gap_q, gap_d;
  logic [BIT_SZ-1:0] k_q, k_d;
  logic              k_valid_q, k_valid_d;
  logic              ovf_q, ovf_d;

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    k_d       = k_q;
    k_valid_d = 1'b0;
    ovf_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // First tick only arms; there is no earlier tick to measure from.
        if (bus.tick_in) begin
          state_d = RUN;
          gap_d   = '0;
        end
      end
      RUN: begin
        if (bus.tick_in) begin
          k_d       = gap_q;
          k_valid_d = 1'b1;
          gap_d     = '0;
        end else if (gap_q == GAP_MAX) begin
          // Counter saturated with no tick: give up and wait to re-arm.
          ovf_d   = 1'b1;
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        gap_d   = '0;
      end
    endcase
  end

  // Stage p0: measurement registers, outputs visible one cycle after the tick
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      k_q       <= '0;
      k_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      k_q       <= k_d;
      k_valid_q <= k_valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.k_out    = k_q;
  assign bus.k_valid  = k_valid_q;
  assign bus.overflow = ovf_q;

`ifdef TICK_PERIOD_LOCK_EN
  localparam logic [7:0] LOCK_TGT = 8'(LOCK_CNT);

  logic [7:0] lock_q, lock_d;
  logic       locked_q, locked_d;

  // A zero count means no measurement since arming, so the next one
  // starts a fresh run regardless of the held k_out.
  always_comb begin
    lock_d = lock_q;
    if (ovf_d) begin
      lock_d = '0;
    end else if (k_valid_d) begin
      if (lock_q == 8'd0 || k_d != k_q) begin
        lock_d = 8'd1;
      end else if (lock_q != LOCK_TGT) begin
        lock_d = lock_q + 8'd1;
      end
    end
    locked_d = (lock_d == LOCK_TGT);
  end

  // Stage p0: lock registers, updated alongside k_valid
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      lock_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      lock_q   <= lock_d;
      locked_q <= locked_d;
    end
  end

  assign bus.locked = locked_q;
`else
  assign bus.locked = 1'b0;
`endif

endmodule

// File: tb/tb_tick_period_meter.sv
module tb_tick_period_meter;

  localparam int LOCK_CNT = 4;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic tick   = 1'b0;

  always #5 clk_in = ~clk_in;

  tick_period_meter_if #(.BIT_SZ(16)) b16 ();
  tick_period_meter_if #(.BIT_SZ(4))  b4 ();

  assign b16.tick_in = tick;
  assign b4.tick_in  = tick;

  tick_period_meter #(.BIT_SZ(16), .LOCK_CNT(LOCK_CNT)) dut16 (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (b16)
  );

  tick_period_meter #(.BIT_SZ(4), .LOCK_CNT(LOCK_CNT)) dut4 (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (b4)
  );

  int checks = 0;
  int errors = 0;

  // Reference model, event based: a measurement is the distance between
  // two tick edges; an overflow happens 2^W edges after the last tick.
  int          ncyc = 0;
  int          wd   [2] = '{16, 4};
  bit          armed[2];
  int          last [2];
  logic [15:0] ek   [2];
  bit          ev   [2];
  bit          eo   [2];
  int          run  [2];
  int          prevk[2];

  task automatic model_edge(input logic t, input logic r);
    int kk;
    ncyc++;
    for (int d = 0; d < 2; d++) begin
      ev[d] = 1'b0;
      eo[d] = 1'b0;
      if (!r) begin
        armed[d] = 1'b0;
        ek[d]    = '0;
        run[d]   = 0;
      end else if (t) begin
        if (armed[d]) begin
          kk    = ncyc - last[d] - 1;
          ev[d] = 1'b1;
          ek[d] = 16'(kk);
          if (run[d] > 0 && kk == prevk[d]) run[d]++;
          else run[d] = 1;
          prevk[d] = kk;
        end
        armed[d] = 1'b1;
        last[d]  = ncyc;
      end else if (armed[d] && (ncyc - last[d]) == (1 << wd[d])) begin
        eo[d]    = 1'b1;
        armed[d] = 1'b0;
        run[d]   = 0;
      end
    end
  endtask

  function automatic logic [18:0] exp_vec(input int d);
    logic lk;
`ifdef TICK_PERIOD_LOCK_EN
    lk = (run[d] >= LOCK_CNT);
`else
    lk = 1'b0;
`endif
    return {ev[d], eo[d], lk, ek[d]};
  endfunction

  function automatic logic [18:0] act_vec(input int d);
    if (d == 0) return {b16.k_valid, b16.overflow, b16.locked, b16.k_out};
    return {b4.k_valid, b4.overflow, b4.locked, 12'd0, b4.k_out};
  endfunction

  task automatic step(input logic t, input logic r);
    tick  = t;
    rst_n = r;
    @(posedge clk_in);
    model_edge(t, r);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom_range(0, 1)), 1'b0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== 19'd0) begin
          errors++;
          $display("FAIL reset dut%0d cyc %0d got %h expected %h", d, ncyc, act_vec(d), 19'd0);
        end
      end
    end
  endtask

  task automatic test_period(input int k, input int nticks, input string name);
    for (int i = 0; i < nticks; i++) begin
      for (int j = 0; j <= k; j++) begin
        step(j == 0, 1'b1);
        for (int d = 0; d < 2; d++) begin
          checks++;
          if (act_vec(d) !== exp_vec(d)) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d got %h expected %h", name, d, ncyc, act_vec(d), exp_vec(d));
          end
        end
      end
    end
  endtask

  task automatic test_held_high();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL held_high dut%0d cyc %0d got %h expected %h", d, ncyc, act_vec(d), exp_vec(d));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    // Tick every 4 cycles; a one-cycle reset lands between the 6th and 7th tick.
    for (int i = 0; i < 40; i++) begin
      step((i % 4) == 0, !(i == 22));
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL reset_mid dut%0d cyc %0d got %h expected %h", d, ncyc, act_vec(d), exp_vec(d));
        end
      end
      if (i == 22) begin
        checks++;
        if (act_vec(0) !== 19'd0) begin
          errors++;
          $display("FAIL reset_mid_clear cyc %0d got %h expected %h", ncyc, act_vec(0), 19'd0);
        end
      end
    end
  endtask

  task automatic test_random();
    int countdown;
    countdown = 0;
    for (int i = 0; i < 3000; i++) begin
      logic t;
      logic r;
      t = (countdown == 0);
      if (t) begin
        // Mostly repeat short periods so lock engages; sometimes long gaps.
        if ($urandom_range(0, 9) < 7) countdown = $urandom_range(0, 3);
        else countdown = $urandom_range(0, 24);
      end else begin
        countdown--;
      end
      r = ($urandom_range(0, 299) != 0);
      step(t, r);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== exp_vec(d)) begin
          errors++;
          $display("FAIL random dut%0d cyc %0d got %h expected %h", d, ncyc, act_vec(d), exp_vec(d));
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      armed[d] = 1'b0;
      last[d]  = 0;
      ek[d]    = '0;
      ev[d]    = 1'b0;
      eo[d]    = 1'b0;
      run[d]   = 0;
      prevk[d] = 0;
    end
    test_reset();
    test_period(3, 6, "k3");
    test_period(5, 6, "k5");
    test_held_high();
    test_period(15, 3, "k15");
    test_period(16, 3, "k16_ovf");
    test_period(2, 5, "k2");
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_period_meter.md
# tick_period_meter

Receive-side companion to the programmable tick divider. It watches a one-cycle tick stream and recovers the divider setting `k` that produced it. The tick stream arrives on the same `clk_in` domain. Ticks repeat every `k+1` cycles, and `k = 0` means the tick is high every cycle. The block reports each measured `k` with a valid strobe and flags overflow; a lock detector can optionally be compiled in. It sits on loopback and monitor paths, where it checks divider outputs and measures external periodic strobes.

## Interface
- `BIT_SZ`, 16, width of the measured interval; matches the divider's `k` width.
- `LOCK_CNT`, 4, number of consecutive identical measurements needed to assert `locked` (legal range 2..255).
- `clk_in`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tick_in`  in  1  tick stream, synchronous to `clk_in`; each high cycle is one tick (level, not edge).
- `k_out`  out  BIT_SZ  last measured `k`, i.e. the number of low cycles between two ticks.
- `k_valid`  out  1  one-cycle strobe; `k_out` was updated this cycle.
- `overflow`  out  1  one-cycle strobe; the gap exceeded `2^BIT_SZ-1` low cycles.
- `locked`  out  1  stable-period indicator (see Configuration).

## Operation
- Internal state:
  - 2-state FSM: IDLE and RUN.
  - Gap counter `gap` (BIT_SZ bits).
  - Lock counter (8 bits, present only when lock is built).
- Reset (`rst_n` low at a rising edge):
  - FSM goes to IDLE; `gap`=0; `k_out`=0; `k_valid`=0; `overflow`=0; `locked`=0; lock counter=0.
  - `tick_in` is ignored while `rst_n` is low.
- IDLE:
  - `tick_in`=1: go to RUN with `gap`=0. No `k_valid`; the first tick only arms the block.
  - `tick_in`=0: stay in IDLE.
- RUN, `tick_in`=1:
  - `k_out`<=`gap`, `k_valid`<=1, `gap`<=0.
  - Stay in RUN.
- RUN, `tick_in`=0, `gap` < `2^BIT_SZ-1`: `gap`<=`gap`+1.
- RUN, `tick_in`=0, `gap` == `2^BIT_SZ-1`:
  - `overflow`<=1 for one cycle and go to IDLE with `gap`=0.
  - `k_out` holds its last value; `locked` and the lock counter clear.
- Width rule: the maximum reportable `k` is `2^BIT_SZ-1`, reached when the tick arrives exactly on the cycle `gap` is saturated. The counter never wraps.
- `k_valid` and `overflow` are never high in the same cycle.

## Timing
- Latency: a tick sampled at edge t produces `k_valid`=1 and the new `k_out` visible after edge t+1 (one register stage).
- `k_out` is stable between strobes.
- Consecutive ticks every cycle (`k`=0) give `k_valid` high continuously after arming, with `k_out`=0.
- Reset mid-measurement aborts it with no strobe. The next tick after release arms the block only.
- Throughput: one measurement per tick, with no dead cycles.

## Configuration
- Macro: `TICK_PERIOD_LOCK_EN`.
- Defined: lock detection is built.
  - On each `k_valid`, if the new value equals the previous `k_out`, the lock counter increments (saturating at `LOCK_CNT`); otherwise it resets to 1.
  - The first measurement after arming sets the counter to 1.
  - `locked`=1 while counter == `LOCK_CNT`. It updates in the same cycle as `k_valid`.
  - A mismatch drops `locked` in the cycle its `k_valid` is shown.
  - Overflow or reset clears both the counter and `locked`.
- Undefined: no comparator or lock counter is built, and `locked` is tied to 0.

## Test plan
- Ticks every 4 cycles (`k`=3), `LOCK_CNT`=4, macro defined:
  - First tick causes no strobe.
  - Each later tick produces `k_valid` one cycle after it, with `k_out`=3.
  - `locked` rises with the 4th `k_valid`.
- `tick_in` held high: after arming, `k_valid`=1 every cycle and `k_out`=0; `locked` rises with the 4th strobe.
- Period changed from `k`=3 to `k`=5 mid-run:
  - The first 5-measurement reports `k_out`=5 and `locked` falls the same cycle.
  - `locked` re-asserts after 4 consecutive 5s.
- `BIT_SZ`=4, tick followed by 15 low cycles then a tick: `k_out`=15, no overflow.
- `BIT_SZ`=4, tick followed by 16 low cycles:
  - `overflow` pulses once, `k_out` unchanged, `locked`=0.
  - The next tick only re-arms.
- `rst_n` low for one cycle between ticks in a locked run: outputs clear, no strobe at the next tick, and measurement resumes at the tick after that. With the macro undefined, `locked` stays 0 throughout every test.
